// File: rtl/id_fwd_scoreboard_pkg.sv
// Shared types and constants for the ID-stage forwarding/hazard scoreboard.
package id_fwd_scoreboard_pkg;

  // Entry fields are sized for the largest supported configuration
  // (RIDX_W <= 8, NSTAGE <= 16); narrower parameters are zero-extended.
  localparam int unsigned SCB_DST_W = 8;
  localparam int unsigned SCB_STG_W = 4;

  localparam int unsigned FSEL_RF  = 0;
  localparam int unsigned STG_EXE  = 0;
  localparam int unsigned STG_MEM  = 1;
  localparam int unsigned STG_MEM2 = 2;
  localparam int unsigned STG_WB   = 3;

  typedef struct packed {
    logic                 vld;
    logic [SCB_DST_W-1:0] dst;
    logic [SCB_STG_W-1:0] rdy_stg;
  } scb_entry_t;

endpackage

// File: rtl/id_fwd_scoreboard_if.sv
// ID-side bus of the forwarding scoreboard; stall_cnt exists only with SCB_STALL_CNT_EN.
interface id_fwd_scoreboard_if #(
  parameter int unsigned NSTAGE = 4,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RIDX_W = 5
);
  localparam int unsigned STG_W  = $clog2(NSTAGE);
  localparam int unsigned FSEL_W = STG_W + 1;

  logic                             adv;
  logic                             id_valid;
  logic                             id_wr;
  logic [RIDX_W-1:0]                id_dst;
  logic [STG_W-1:0]                 id_rdy_stg;
  logic [NREAD-1:0][RIDX_W-1:0]     id_src;
  logic [NREAD-1:0]                 id_src_use;
  logic [NREAD-1:0][DATA_W-1:0]     rf_data;
  logic [NSTAGE-1:0][DATA_W-1:0]    stg_result;
  logic [NSTAGE-1:0]                flush_mask;
  logic [NREAD-1:0][DATA_W-1:0]     opnd;
  logic [NREAD-1:0][FSEL_W-1:0]     fwd_sel;
  logic                             stall;
`ifdef SCB_STALL_CNT_EN
  logic [31:0]                      stall_cnt;
`endif

  modport master (
    output adv, id_valid, id_wr, id_dst, id_rdy_stg, id_src, id_src_use, rf_data,
           stg_result, flush_mask,
    input  opnd, fwd_sel, stall
`ifdef SCB_STALL_CNT_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  adv, id_valid, id_wr, id_dst, id_rdy_stg, id_src, id_src_use, rf_data,
           stg_result, flush_mask,
    output opnd, fwd_sel, stall
`ifdef SCB_STALL_CNT_EN
    , output stall_cnt
`endif
  );

endinterface

// File: rtl/id_fwd_scoreboard_port_resolve.sv
// One read port: youngest-match search, forward mux and hazard flag.
module scb_port_resolve
  import id_fwd_scoreboard_pkg::*;
#(
  parameter int unsigned NSTAGE = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RIDX_W = 5,
  parameter int unsigned FSEL_W = $clog2(NSTAGE) + 1
) (
  input  scb_entry_t [NSTAGE-1:0]             entries,
  input  logic       [RIDX_W-1:0]             src,
  input  logic                                src_use,
  input  logic       [DATA_W-1:0]             rf_data,
  input  logic       [NSTAGE-1:0][DATA_W-1:0] stg_result,
  output logic       [DATA_W-1:0]             opnd,
  output logic       [FSEL_W-1:0]             fwd_sel,
  output logic                                hazard
);

  logic found;

  // Stage 0 is the youngest writer; once found, older writers are shadowed.
  always_comb begin
    opnd    = rf_data;
    fwd_sel = FSEL_W'(FSEL_RF);
    hazard  = 1'b0;
    found   = 1'b0;
    for (int s = 0; s < NSTAGE; s++) begin
      if (!found && entries[s].vld && src_use && (src != '0) &&
          (entries[s].dst == SCB_DST_W'(src))) begin
        found = 1'b1;
        if (s >= int'(entries[s].rdy_stg)) begin
          opnd    = stg_result[s];
          fwd_sel = FSEL_W'(s + 1);
        end else begin
          hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/id_fwd_scoreboard.sv
// Operand-forwarding and load-use scoreboard for the ID stage.
// Optional stall-cycle counter enabled by defining SCB_STALL_CNT_EN.
module id_fwd_scoreboard
  import id_fwd_scoreboard_pkg::*;
#(
  parameter int unsigned NSTAGE = 4,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RIDX_W = 5
) (
  input logic                clk,
  input logic                rst,
  id_fwd_scoreboard_if.slave bus
);

  localparam int unsigned FSEL_W = $clog2(NSTAGE) + 1;

  scb_entry_t [NSTAGE-1:0] entries_q, entries_d;
  logic       [NREAD-1:0]  hazard;
  logic                    stall;

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    scb_port_resolve #(
      .NSTAGE (NSTAGE),
      .DATA_W (DATA_W),
      .RIDX_W (RIDX_W),
      .FSEL_W (FSEL_W)
    ) u_port (
      .entries    (entries_q),
      .src        (bus.id_src[p]),
      .src_use    (bus.id_src_use[p]),
      .rf_data    (bus.rf_data[p]),
      .stg_result (bus.stg_result),
      .opnd       (bus.opnd[p]),
      .fwd_sel    (bus.fwd_sel[p]),
      .hazard     (hazard[p])
    );
  end

  assign stall     = bus.id_valid & (|hazard);
  assign bus.stall = stall;

  // Shift or hold first, then the flush mask kills post-shift positions.
  always_comb begin
    entries_d = entries_q;
    if (bus.adv) begin
      for (int s = NSTAGE - 1; s > 0; s--) begin
        entries_d[s] = entries_q[s-1];
      end
      entries_d[STG_EXE] = '0;
      if (bus.id_valid && bus.id_wr && !stall) begin
        entries_d[STG_EXE].vld     = 1'b1;
        entries_d[STG_EXE].dst     = SCB_DST_W'(bus.id_dst);
        entries_d[STG_EXE].rdy_stg = SCB_STG_W'(bus.id_rdy_stg);
      end
    end
    for (int s = 0; s < NSTAGE; s++) begin
      if (bus.flush_mask[s]) begin
        entries_d[s] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries_q <= '0;
    end else begin
      entries_q <= entries_d;
    end
  end

`ifdef SCB_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_fwd_scoreboard.sv
// Self-checking bench for id_fwd_scoreboard: directed scenarios plus randomized traffic
// against an array-based model of the in-flight writers.
module tb_id_fwd_scoreboard;
  import id_fwd_scoreboard_pkg::*;

  localparam int unsigned NSTAGE = 4;
  localparam int unsigned NREAD  = 2;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RIDX_W = 5;
  localparam int unsigned STG_W  = $clog2(NSTAGE);

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  id_fwd_scoreboard_if #(
    .NSTAGE (NSTAGE), .NREAD (NREAD), .DATA_W (DATA_W), .RIDX_W (RIDX_W)
  ) bus ();

  id_fwd_scoreboard #(
    .NSTAGE (NSTAGE), .NREAD (NREAD), .DATA_W (DATA_W), .RIDX_W (RIDX_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: one slot per post-ID stage holding the pending writer, if any.
  bit m_vld [NSTAGE];
  int m_dst [NSTAGE];
  int m_rdy [NSTAGE];
`ifdef SCB_STALL_CNT_EN
  logic [31:0] m_cnt;
`endif

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NSTAGE; s++) begin
      m_vld[s] = 1'b0;
      m_dst[s] = 0;
      m_rdy[s] = 0;
    end
`ifdef SCB_STALL_CNT_EN
    m_cnt = '0;
`endif
  endtask

  task automatic model_port(input int p, output bit haz, output int sel,
                            output logic [DATA_W-1:0] data);
    haz  = 1'b0;
    sel  = 0;
    data = bus.rf_data[p];
    for (int s = 0; s < NSTAGE; s++) begin
      if (m_vld[s] && bus.id_src_use[p] && (bus.id_src[p] != 0) &&
          (m_dst[s] == int'(bus.id_src[p]))) begin
        if (s >= m_rdy[s]) begin
          sel  = s + 1;
          data = bus.stg_result[s];
        end else begin
          haz = 1'b1;
        end
        return;
      end
    end
  endtask

  task automatic model_stall(output bit st);
    bit haz;
    int sel;
    logic [DATA_W-1:0] data;
    st = 1'b0;
    for (int p = 0; p < NREAD; p++) begin
      model_port(p, haz, sel, data);
      if (haz) st = 1'b1;
    end
    st = st && bus.id_valid;
  endtask

  // Called right after a rising edge, while the inputs of that edge are still driven.
  task automatic model_update();
    bit st;
    model_stall(st);
`ifdef SCB_STALL_CNT_EN
    if (st && (m_cnt != '1)) m_cnt = m_cnt + 32'd1;
`endif
    if (bus.adv) begin
      for (int s = NSTAGE - 1; s > 0; s--) begin
        m_vld[s] = m_vld[s-1];
        m_dst[s] = m_dst[s-1];
        m_rdy[s] = m_rdy[s-1];
      end
      m_vld[0] = bus.id_valid && bus.id_wr && !st;
      m_dst[0] = int'(bus.id_dst);
      m_rdy[0] = int'(bus.id_rdy_stg);
    end
    for (int s = 0; s < NSTAGE; s++) begin
      if (bus.flush_mask[s]) m_vld[s] = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    bit haz;
    bit st;
    int sel;
    logic [DATA_W-1:0] data;
    for (int p = 0; p < NREAD; p++) begin
      model_port(p, haz, sel, data);
      if (!haz) begin
        check_eq($sformatf("%s_sel%0d", tag, p), 64'(bus.fwd_sel[p]), 64'(sel));
        check_eq($sformatf("%s_opnd%0d", tag, p), 64'(bus.opnd[p]), 64'(data));
      end
    end
    model_stall(st);
    check_eq({tag, "_stall"}, 64'(bus.stall), 64'(st));
`ifdef SCB_STALL_CNT_EN
    check_eq({tag, "_cnt"}, 64'(bus.stall_cnt), 64'(m_cnt));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    bus.adv        = 1'b0;
    bus.id_valid   = 1'b0;
    bus.id_wr      = 1'b0;
    bus.id_dst     = '0;
    bus.id_rdy_stg = '0;
    bus.id_src     = '0;
    bus.id_src_use = '0;
    bus.stg_result = '0;
    bus.flush_mask = '0;
    bus.rf_data[0] = 32'h1234;
    bus.rf_data[1] = 32'h5678;
  endtask

  task automatic clear_pipe();
    idle();
    bus.flush_mask = '1;
    tick();
    bus.flush_mask = '0;
  endtask

  task automatic issue(input int dst, input int rdy);
    bus.adv        = 1'b1;
    bus.id_valid   = 1'b1;
    bus.id_wr      = 1'b1;
    bus.id_dst     = RIDX_W'(dst);
    bus.id_rdy_stg = STG_W'(rdy);
    bus.id_src_use = '0;
    tick();
    bus.id_wr      = 1'b0;
  endtask

  task automatic read0(input int src);
    bus.id_src[0]     = RIDX_W'(src);
    bus.id_src_use[0] = 1'b1;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    idle();
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset defaults
    bus.id_valid   = 1'b1;
    bus.id_src[0]  = 5'd1;
    bus.id_src[1]  = 5'd2;
    bus.id_src_use = 2'b11;
    #1;
    check_eq("rst_opnd", 64'(bus.opnd[0]), 64'(32'h1234));
    check_eq("rst_sel", 64'(bus.fwd_sel[0]), 64'(0));
    check_eq("rst_stall", 64'(bus.stall), 64'(0));

    // ALU forward
    clear_pipe();
    issue(5, 0);
    read0(5);
    bus.stg_result[STG_EXE] = 32'hAA;
    #1;
    check_eq("alu_sel", 64'(bus.fwd_sel[0]), 64'(1));
    check_eq("alu_opnd", 64'(bus.opnd[0]), 64'(32'hAA));
    check_eq("alu_stall", 64'(bus.stall), 64'(0));

    // Load-use: two stall cycles with adv=1, then forwarded from stage 2
    clear_pipe();
    issue(7, 2);
    read0(7);
    bus.stg_result[STG_MEM2] = 32'h77;
    #1;
    check_eq("lu_stall0", 64'(bus.stall), 64'(1));
    tick();
    check_eq("lu_stall1", 64'(bus.stall), 64'(1));
    tick();
    check_eq("lu_stall2", 64'(bus.stall), 64'(0));
    check_eq("lu_sel", 64'(bus.fwd_sel[0]), 64'(3));
    check_eq("lu_opnd", 64'(bus.opnd[0]), 64'(32'h77));

    // Youngest match wins
    clear_pipe();
    issue(3, 0);
    bus.id_wr = 1'b0;
    tick();
    issue(3, 0);
    read0(3);
    bus.id_src[1]     = 5'd3;
    bus.id_src_use[1] = 1'b1;
    bus.stg_result[STG_MEM2] = 32'h11;
    bus.stg_result[STG_EXE]  = 32'h22;
    #1;
    check_eq("yw_opnd", 64'(bus.opnd[0]), 64'(32'h22));
    check_eq("yw_sel", 64'(bus.fwd_sel[0]), 64'(1));
    check_eq("yw_sel_p1", 64'(bus.fwd_sel[1]), 64'(1));

    // Writes to the zero register never forward
    clear_pipe();
    issue(0, 0);
    read0(0);
    #1;
    check_eq("z_sel", 64'(bus.fwd_sel[0]), 64'(0));
    check_eq("z_opnd", 64'(bus.opnd[0]), 64'(32'h1234));

    // Flush of stage 0 without advance clears a load-use hazard
    clear_pipe();
    issue(4, 2);
    read0(4);
    #1;
    check_eq("fl_stall_pre", 64'(bus.stall), 64'(1));
    bus.adv        = 1'b0;
    bus.flush_mask = 4'b0001;
    tick();
    bus.flush_mask = '0;
    check_eq("fl_stall", 64'(bus.stall), 64'(0));
    check_eq("fl_sel", 64'(bus.fwd_sel[0]), 64'(0));
    check_eq("fl_opnd", 64'(bus.opnd[0]), 64'(32'h1234));

    // Forward from WB
    clear_pipe();
    issue(6, 0);
    bus.id_valid = 1'b0;
    repeat (3) tick();
    read0(6);
    bus.id_valid = 1'b1;
    bus.stg_result[STG_WB] = 32'hB0B0;
    #1;
    check_eq("wb_sel", 64'(bus.fwd_sel[0]), 64'(4));
    check_eq("wb_opnd", 64'(bus.opnd[0]), 64'(32'hB0B0));

    // Asynchronous reset clears a pending hazard between edges
    clear_pipe();
    issue(9, 2);
    read0(9);
    #1;
    check_eq("ar_pre", 64'(bus.stall), 64'(1));
    #1 rst = 1'b1;
    #1;
    check_eq("ar_stall", 64'(bus.stall), 64'(0));
    check_eq("ar_sel", 64'(bus.fwd_sel[0]), 64'(0));
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;

`ifdef SCB_STALL_CNT_EN
    // Hazard held for five cycles
    issue(7, 2);
    read0(7);
    bus.adv = 1'b0;
    repeat (5) tick();
    check_eq("sc_cnt", 64'(bus.stall_cnt), 64'(5));
`endif

    // Randomized traffic against the model
    clear_pipe();
    for (int i = 0; i < 800; i++) begin
      bus.adv        = ($urandom_range(0, 3) != 0);
      bus.id_valid   = ($urandom_range(0, 3) != 0);
      bus.id_wr      = ($urandom_range(0, 2) != 0);
      bus.id_dst     = RIDX_W'($urandom_range(0, 7));
      bus.id_rdy_stg = STG_W'($urandom_range(0, 2));
      for (int p = 0; p < NREAD; p++) begin
        bus.id_src[p]     = RIDX_W'($urandom_range(0, 7));
        bus.id_src_use[p] = ($urandom_range(0, 3) != 0);
        bus.rf_data[p]    = $urandom;
      end
      for (int s = 0; s < NSTAGE; s++) bus.stg_result[s] = $urandom;
      bus.flush_mask = ($urandom_range(0, 9) == 0) ? NSTAGE'($urandom) : '0;
      #1;
      check_all("rnd");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_fwd_scoreboard.md
# id_fwd_scoreboard

Parametrised operand-forwarding and data-hazard scoreboard for the ID stage. It replaces the fixed per-stage forward-select and load-use logic with one block. The block tracks every in-flight register write in a shift pipeline of `NSTAGE` post-ID stages and records, per entry, the stage at which the result becomes available. For each of `NREAD` ID read ports it returns either the forwarded operand or the register-file value, plus a single stall request. It sits between the register file and the ID/EXE boundary.

## Interface
Parameters:
- `NSTAGE`, 4: number of post-ID stages tracked; index 0 = EXE, NSTAGE-1 = WB.
- `NREAD`, 2: number of ID read ports.
- `DATA_W`, 32: operand width.
- `RIDX_W`, 5: register index width; index 0 is hard-wired zero.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `adv`  in  1  the pipeline past ID advances this cycle.
- `id_valid`  in  1  ID holds a valid instruction.
- `id_wr`  in  1  the ID instruction writes a register.
- `id_dst`  in  RIDX_W  destination register of the ID instruction.
- `id_rdy_stg`  in  $clog2(NSTAGE)  first stage whose result bus carries the value (ALU=0, MFC0=1, load=2).
- `id_src`  in  NREAD×RIDX_W  source indices.
- `id_src_use`  in  NREAD  the source is actually read.
- `rf_data`  in  NREAD×DATA_W  register-file read data.
- `stg_result`  in  NSTAGE×DATA_W  per-stage result buses.
- `flush_mask`  in  NSTAGE  kill the entries in the marked stages.
- `opnd`  out  NREAD×DATA_W  resolved operands.
- `fwd_sel`  out  NREAD×($clog2(NSTAGE)+1)  source of each operand: 0 = RF, s+1 = stage s.
- `stall`  out  1  the ID instruction cannot issue.
- `stall_cnt`  out  32  stall-cycle counter (present only with the macro).

## Operation
- Entry fields are {vld, dst, rdy_stg}. A bubble has vld=0.
- **Match.** Stage s matches port p when all of the following hold: vld, id_src_use[p], id_src[p]≠0, and dst==id_src[p].
- **Youngest match.** For each port, take the lowest-indexed matching stage m.
  - If m ≥ rdy_stg[m]: forward. opnd = stg_result[m] and fwd_sel = m+1.
  - If m < rdy_stg[m]: the port is hazarded.
  - If no stage matches: opnd = rf_data and fwd_sel = 0.
  - Older matches behind the youngest one are ignored.
- **Stall.** stall = id_valid & (any port hazarded). It is purely combinational. A hazarded port's opnd is don't-care.
- **Advance.** When adv=1, entries shift s → s+1 and the WB entry retires. Stage 0 loads {1, id_dst, id_rdy_stg} if id_valid & id_wr & ~stall & ~flush_mask[0]; otherwise it loads a bubble.
- **Hold.** When adv=0, the entries hold.
- **Flush.** flush_mask is applied after the shift or hold. A marked stage becomes a bubble on the same clock edge. A flush in the same cycle as an advance acts on the post-shift positions.
- **Non-writers.** An instruction with id_wr=0 enters as a bubble.

## Timing
- Forward and stall outputs have zero latency (combinational from inputs and state).
- Scoreboard state updates on the rising clk edge.
- Reset: all entries are bubbles, stall=0, and every fwd_sel=0, so opnd equals rf_data. stall_cnt resets to 0.
- A reset asserted mid-operation clears the entries immediately (asynchronous). Outputs are valid from the next evaluation.
- Boundary: a write in WB is forwarded from stage NSTAGE-1. The RF is written at the same edge, so the next cycle reads the RF.

## Configuration
- `SCB_STALL_CNT_EN` defined: `stall_cnt` increments by 1 each cycle that stall=1 and saturates at 32'hFFFF_FFFF.
- Without the macro, the port and the counter are absent.

## Structure
- The shared package holds the `scb_entry_t` struct {vld, dst, rdy_stg}.
- The package also holds the localparams `FSEL_RF=0` and the stage indices `STG_EXE`, `STG_MEM`, `STG_MEM2`, `STG_WB`.
- One sub-module, `scb_port_resolve`, is instantiated NREAD times. It performs the priority match, forward mux and hazard flag for one port.

## Test plan
- **Reset defaults.** Assert rst, then release. With rf_data[0]=32'h1234 → opnd[0]=32'h1234, fwd_sel=0, stall=0.
- **ALU forward.** Issue r5 with rdy_stg=0 and result 32'hAA. Next cycle, read r5 → fwd_sel=1, opnd=32'hAA, stall=0.
- **Load-use hazard.**
  - Issue a load to r7 with rdy_stg=2. The next ID reads r7 → stall=1 for 2 cycles with adv=1.
  - In the 3rd cycle → fwd_sel=3, stall=0.
- **Youngest wins.** r3 in stage 2 carries 32'h11 and r3 in stage 0 carries 32'h22 (rdy_stg=0) → opnd=32'h22, fwd_sel=1.
- **Zero register and flush.**
  - r0 in stage 0 → fwd_sel=0.
  - A load to r4 in stage 0 while r4 is read (stall=1). Set flush_mask=4'b0001 together with adv=0 → stall=0 the next cycle and opnd=rf_data.
- **Stall counter.** Build with SCB_STALL_CNT_EN and hold a hazard for 5 cycles → stall_cnt=5.
